// File: rtl/uart_rx_ctrl_if.sv
// Control/status bundle between the UART receive controller and its datapath.
// The package carries the control-point struct shared by both sides.
package uart_rx_ctrl_pkg;

  // Each field is packed {en, clr}; clr takes priority in the datapath.
  typedef struct packed {
    logic [1:0] clk_ctrl;
    logic [1:0] sample_ctrl;
    logic [1:0] bit_ctrl;
    logic [1:0] data_ctrl;
  } controlPoints_t;

endpackage

// Datapath link: the controller (master) drives cPts, and the datapath (slave)
// returns its counter status flags.
interface uart_rx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  import uart_rx_ctrl_pkg::*;

  logic                          sample;
  logic                          mid_bit;
  logic [$clog2(DATA_WIDTH)-1:0] bit_count;
  controlPoints_t                cPts;

  modport master (input sample, input mid_bit, input bit_count, output cPts);
  modport slave  (output sample, output mid_bit, output bit_count, input cPts);

endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller. It synchronises rx, sequences the datapath
// counters and shift register, and flags each frame with a one-cycle
// rx_valid or frame_err pulse.
// Optional macro UART_RX_PARITY_EN adds an even-parity bit between the data
// and stop bits, together with the parity_err output.
//
// Datapath handshake: the controller never waits on the datapath. Each cycle
// it presents cPts computed from state, sample, mid_bit, bit_count and
// rx_sync. The datapath applies those controls on the next clock edge. A
// strobe (sample & mid_bit) is the only event that advances the frame.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx,
  uart_rx_ctrl_if.master   dp,
  output logic             rx_sync,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             busy,
`ifdef UART_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic [2:0]       state_dbg
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  // Both parameters must be powers of two so the datapath counters wrap naturally.
  if (DATA_WIDTH < 2 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_dw
    $error("uart_rx_ctrl: DATA_WIDTH must be a power of two >= 2");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
    $error("uart_rx_ctrl: OVERSAMPLE must be a power of two >= 4");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } state_t;

  state_t         state, state_next;
  logic           sync_1;
  logic           strobe;
  logic           valid_next, err_next;
  controlPoints_t cpts_c;

  // Centre-of-bit pulse: last clock of the middle oversample.
  assign strobe = dp.sample & dp.mid_bit;

  // Two-flop synchroniser on the raw line. Both flops reset to idle (high).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_1  <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      sync_1  <= rx;
      rx_sync <= sync_1;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and Mealy control points for the datapath.
  always_comb begin
    state_next         = state;
    valid_next         = 1'b0;
    err_next           = 1'b0;
    // IDLE controls: hold every counter cleared and keep the last byte.
    cpts_c.clk_ctrl    = 2'b01;
    cpts_c.sample_ctrl = 2'b01;
    cpts_c.bit_ctrl    = 2'b01;
    cpts_c.data_ctrl   = 2'b00;

    if (state != IDLE) begin
      // clk_count clears on its terminal cycle instead of counting past it.
      cpts_c.clk_ctrl    = {~dp.sample, dp.sample};
      cpts_c.sample_ctrl = {dp.sample, 1'b0};
      cpts_c.bit_ctrl    = 2'b00;
    end

    case (state)
      IDLE: begin
        if (!rx_sync) state_next = START;
      end
      START: begin
        // A high line at mid-start is a glitch: drop back silently.
        if (strobe) state_next = rx_sync ? IDLE : DATA;
      end
      DATA: begin
        if (strobe) begin
          cpts_c.data_ctrl = 2'b10;
          cpts_c.bit_ctrl  = 2'b10;
          if (dp.bit_count == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (strobe) state_next = STOP;
      end
`endif
      STOP: begin
        // Leaving at mid-stop lets a back-to-back start edge be caught.
        if (strobe) begin
          valid_next = rx_sync;
          err_next   = ~rx_sync;
          state_next = IDLE;
        end
      end
      default: begin
        state_next         = IDLE;
        cpts_c.clk_ctrl    = 2'b01;
        cpts_c.sample_ctrl = 2'b01;
        cpts_c.bit_ctrl    = 2'b01;
        cpts_c.data_ctrl   = 2'b00;
      end
    endcase
  end

  assign dp.cPts   = cpts_c;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Registered frame-result pulses, one cycle after the stop-bit strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= valid_next;
      frame_err <= err_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_acc;
  logic par_bad;

  // Running XOR of data bits, checked against the parity bit, reported at stop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      if (state == IDLE) begin
        par_acc <= 1'b0;
        par_bad <= 1'b0;
      end else if (state == DATA && strobe) begin
        par_acc <= par_acc ^ rx_sync;
      end else if (state == PARITY && strobe) begin
        par_bad <= par_acc ^ rx_sync;
      end else if (state == STOP && strobe) begin
        parity_err <= par_bad;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with a behavioural datapath model.
module tb_uart_rx_ctrl;
  import uart_rx_ctrl_pkg::*;

  localparam int DW  = 8;
  localparam int OS  = 16;
  localparam int CPS = 8;
  localparam int BIT = OS * CPS;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = DW + 3;
`else
  localparam int FRAME_BITS = DW + 2;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;
  always #5 clock = ~clock;

  logic       rx_sync, rx_valid, frame_err, busy;
  logic [2:0] state_dbg;
  logic       perr_obs;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  assign perr_obs = parity_err;
`else
  assign perr_obs = 1'b0;
`endif

  uart_rx_ctrl_if #(.DATA_WIDTH(DW)) dp_if ();

  uart_rx_ctrl #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .dp        (dp_if.master),
    .rx_sync   (rx_sync),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .state_dbg (state_dbg)
  );

  // ---------------- datapath model ----------------
  logic [3:0] clk_count    = '0;
  logic [3:0] sample_count = '0;
  logic [2:0] bit_cnt      = '0;
  logic [7:0] data_out     = '0;

  always @(posedge clock) begin
    if (dp_if.cPts.clk_ctrl[0])         clk_count <= '0;
    else if (dp_if.cPts.clk_ctrl[1])    clk_count <= clk_count + 4'd1;
    if (dp_if.cPts.sample_ctrl[0])      sample_count <= '0;
    else if (dp_if.cPts.sample_ctrl[1]) sample_count <= sample_count + 4'd1;
    if (dp_if.cPts.bit_ctrl[0])         bit_cnt <= '0;
    else if (dp_if.cPts.bit_ctrl[1])    bit_cnt <= bit_cnt + 3'd1;
    if (dp_if.cPts.data_ctrl[0])        data_out <= '0;
    else if (dp_if.cPts.data_ctrl[1])   data_out <= {rx_sync, data_out[7:1]};
  end

  assign dp_if.sample    = (clk_count == 4'(CPS - 1));
  assign dp_if.mid_bit   = (sample_count == 4'(OS / 2 - 1));
  assign dp_if.bit_count = bit_cnt;

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];      // {parity_err, data} expected with rx_valid
  logic [8:0] err_exp_q[$];  // {parity_err, data} expected with frame_err
  int unsigned valid_times[$];
  int unsigned cyc = 0;
  int total = 0;
  int bad   = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int unsigned start_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  localparam controlPoints_t IDLE_C = '{clk_ctrl: 2'b01, sample_ctrl: 2'b01,
                                        bit_ctrl: 2'b01, data_ctrl: 2'b00};

  // Monitor: pops an expectation for every result pulse.
  initial begin : monitor
    logic       prev_pulse;
    logic [8:0] obs, exp;
    prev_pulse = 1'b0;
    forever begin
      @(negedge clock);
      obs = {perr_obs, data_out};
      if (rx_valid || frame_err) begin
        total++;
        if (rx_valid && frame_err) begin
          bad++;
          $display("FAIL exclusive: rx_valid=%b frame_err=%b required not both", rx_valid, frame_err);
        end
        total++;
        if (prev_pulse) begin
          bad++;
          $display("FAIL pulse_width: result pulse high for 2+ cycles at cyc %0d, required 1", cyc);
        end
      end
      if (rx_valid) begin
        valid_cnt++;
        valid_times.push_back(cyc);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid: got %h with no frame pending", obs);
        end else begin
          exp = exp_q.pop_front();
          if (obs !== exp) begin
            bad++;
            $display("FAIL valid_data: got {perr,data}=%h required %h", obs, exp);
          end
        end
      end
      if (frame_err) begin
        err_cnt++;
        total++;
        if (err_exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_frame_err: got %h with no bad frame pending", obs);
        end else begin
          exp = err_exp_q.pop_front();
          if (obs !== exp) begin
            bad++;
            $display("FAIL err_data: got {perr,data}=%h required %h", obs, exp);
          end
        end
      end
      if (perr_obs && !(rx_valid || frame_err)) begin
        total++;
        bad++;
        $display("FAIL parity_alone: parity_err pulsed without a result pulse at cyc %0d", cyc);
      end
      prev_pulse = rx_valid || frame_err;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic b);
    @(negedge clock);
    rx = b;
    repeat (BIT - 1) @(negedge clock);
  endtask

  task automatic idle_bits(input int n);
    @(negedge clock);
    rx = 1'b1;
    repeat (n * BIT - 1) @(negedge clock);
  endtask

  // Sends one frame and queues its expected outcome; par_b is the parity bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    logic perr;
`ifdef UART_RX_PARITY_EN
    perr = (^d) ^ par_b;
`else
    perr = 1'b0 & par_b;
`endif
    if (stop_b) exp_q.push_back({perr, d});
    else        err_exp_q.push_back({perr, d});
    @(negedge clock);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (BIT - 1) @(negedge clock);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b);
`endif
    drive_bit(stop_b);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || err_exp_q.size() != 0) && n < 4 * BIT) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (exp_q.size() != 0 || err_exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: pending valid=%0d err=%0d required 0", name, exp_q.size(), err_exp_q.size());
      exp_q.delete();
      err_exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clock);
    total++; if (rx_sync !== 1'b1) begin bad++; $display("FAIL rst_rx_sync: got %b required 1", rx_sync); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rx_valid: got %b required 0", rx_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_frame_err: got %b required 0", frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
    total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL rst_state: got %0d required 0", state_dbg); end
    total++; if (dp_if.cPts !== IDLE_C) begin bad++; $display("FAIL rst_cpts: got %b required %b", dp_if.cPts, IDLE_C); end
    reset = 1'b0;
    idle_bits(1);
  endtask

  task automatic test_basic();
    int v0, e0;
    int unsigned dt;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle_bits(1);
    wait_drain("basic");
    total++; if (valid_cnt != v0 + 1) begin bad++; $display("FAIL basic_valid_count: got %0d required %0d", valid_cnt - v0, 1); end
    total++; if (err_cnt != e0) begin bad++; $display("FAIL basic_frame_err: got %0d pulses required 0", err_cnt - e0); end
    dt = (valid_times.size() > 0) ? valid_times[$] - start_cyc : 0;
    total++;
    if (dt < (BIT * (2 * FRAME_BITS - 1)) / 2 || dt > (BIT * (2 * FRAME_BITS - 1)) / 2 + 4) begin
      bad++;
      $display("FAIL basic_latency: got %0d cycles required about %0d", dt, (BIT * (2 * FRAME_BITS - 1)) / 2 + 3);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b required 0", busy); end
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    @(negedge clock);
    rx = 1'b0;
    repeat (20) @(negedge clock);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_during: got %b required 1", busy); end
    repeat (20) @(negedge clock);
    rx = 1'b1;
    repeat (BIT) @(negedge clock);
    total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL glitch_state: got %0d required 0", state_dbg); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_after: got %b required 0", busy); end
    total++; if (valid_cnt != v0 || err_cnt != e0) begin
      bad++; $display("FAIL glitch_pulses: got valid=%0d err=%0d required 0 0", valid_cnt - v0, err_cnt - e0);
    end
  endtask

  task automatic test_framing();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    idle_bits(2);
    wait_drain("framing");
    total++; if (err_cnt != e0 + 1 || valid_cnt != v0) begin
      bad++; $display("FAIL framing_pulses: got err=%0d valid=%0d required 1 0", err_cnt - e0, valid_cnt - v0);
    end
    send_frame(8'h81, 1'b1, ^8'h81);
    idle_bits(1);
    wait_drain("after_framing");
    total++; if (valid_cnt != v0 + 1) begin bad++; $display("FAIL after_framing_valid: got %0d required 1", valid_cnt - v0); end
  endtask

  task automatic test_back_to_back();
    int n0;
    int unsigned gap;
    n0 = valid_times.size();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle_bits(1);
    wait_drain("b2b");
    total++;
    if (valid_times.size() != n0 + 2) begin
      bad++; $display("FAIL b2b_count: got %0d required 2", valid_times.size() - n0);
    end else begin
      gap = valid_times[n0 + 1] - valid_times[n0];
      total++;
      if (gap != FRAME_BITS * BIT) begin
        bad++; $display("FAIL b2b_gap: got %0d cycles required %0d", gap, FRAME_BITS * BIT);
      end
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    logic [7:0] d;
    d = 8'hC3;
    @(negedge clock);
    rx = 1'b0;
    repeat (BIT - 1) @(negedge clock);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    @(negedge clock);
    rx = d[4];
    repeat (BIT / 2) @(negedge clock);
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b required 0", busy); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b required 0", rx_valid); end
    total++; if (rx_sync !== 1'b1) begin bad++; $display("FAIL midrst_rx_sync: got %b required 1", rx_sync); end
    total++; if (dp_if.cPts !== IDLE_C) begin bad++; $display("FAIL midrst_cpts: got %b required %b", dp_if.cPts, IDLE_C); end
    rx = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    idle_bits(1);
    v0 = valid_cnt;
    send_frame(8'h5A, 1'b1, ^8'h5A);
    idle_bits(1);
    wait_drain("midrst");
    total++; if (valid_cnt != v0 + 1) begin bad++; $display("FAIL midrst_after_valid: got %0d required 1", valid_cnt - v0); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int v0;
    v0 = valid_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(1);
    send_frame(8'h07, 1'b1, 1'b0);
    idle_bits(1);
    wait_drain("parity");
    total++; if (valid_cnt != v0 + 2) begin bad++; $display("FAIL parity_valid: got %0d required 2", valid_cnt - v0); end
  endtask
`endif

  initial begin : watchdog
    repeat (90000) @(posedge clock);
    $display("FAIL watchdog: cycle budget exhausted");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- FSM controller that sequences the UART receive datapath: counters for clock-per-sample, oversample and bit, plus the SIPO data register.
- Drives the datapath's controlPoints_t bundle from the datapath status flags (sample, mid_bit, bit_count).
- Synchronises the raw rx line, validates start and stop bits, and reports each received byte with a one-cycle valid pulse or a framing-error pulse.

Parameters:
- DATA_WIDTH, 8, data bits per frame; must match datapath; power of two.
- OVERSAMPLE, 16, samples per bit; must match datapath; power of two, >= 4.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx  input  1  raw serial line, idle high
- sample  input  1  datapath flag: clk_count at terminal value
- mid_bit  input  1  datapath flag: sample_count == OVERSAMPLE/2-1
- bit_count  input  $clog2(DATA_WIDTH)  datapath bit counter
- rx_sync  output  1  synchronised rx; feeds datapath data_in
- cPts  output  controlPoints_t  fields clk_ctrl, sample_ctrl, bit_ctrl, data_ctrl, each 2 bits packed {en, clr}
- rx_valid  output  1  one-cycle pulse; datapath data_out holds a complete byte
- frame_err  output  1  one-cycle pulse; stop bit sampled low
- busy  output  1  high in any state other than IDLE

Behaviour:
- Synchroniser: 2-flop chain on rx; both flops reset to 1; rx_sync is the second flop. Latency is 2 clocks.
- strobe = sample & mid_bit. This is a one-cycle pulse at the centre of each bit.
- States: IDLE, START, DATA, STOP. State reset value is IDLE.
- All cPts outputs are Mealy combinational from state and inputs. rx_valid and frame_err are registered.
- IDLE:
  - clk, sample and bit clr = 1; all en = 0; data_ctrl = 00, so the last byte is retained.
  - rx_sync == 0 -> START on the next edge.
- START, DATA and STOP share the counter control:
  - clk_ctrl = {~sample, sample}. The clear on the terminal cycle implements the wrap.
  - sample_ctrl = {sample, 0}. The sample counter wraps naturally at OVERSAMPLE.
- START:
  - On strobe with rx_sync == 0 -> DATA.
  - On strobe with rx_sync == 1 (false start/glitch) -> IDLE, with no pulse.
- DATA:
  - On strobe, data_ctrl = 10 (shift in rx_sync, LSB first) and bit_ctrl = 10.
  - If bit_count == DATA_WIDTH-1 on strobe -> STOP. bit_count wraps to 0.
- STOP:
  - On strobe with rx_sync == 1: rx_valid = 1 for the next cycle.
  - On strobe with rx_sync == 0: frame_err = 1 for the next cycle. data_out still holds the shifted bits.
  - Either case -> IDLE.
- Exit at mid-stop-bit is intentional so the next start edge can be caught. Back-to-back frames need no idle gap.
- rx_valid and frame_err are mutually exclusive and never high more than one cycle.
- Reset mid-frame:
  - Immediate return to IDLE; outputs go to reset values; synchroniser reloads 1.
  - Counters are cleared on the first clocked IDLE cycle.
- Reset values: rx_sync = 1, rx_valid = 0, frame_err = 0, busy = 0. cPts follows IDLE: clr = 1, en = 0, data = 00.
- Timing: frame time = (DATA_WIDTH+2) bit periods; one bit period = OVERSAMPLE × CLKS_PER_SAMPLE clocks.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP; DATA exits to PARITY instead of STOP.
  - A parity register clears in IDLE and XORs rx_sync on each DATA strobe.
  - On the PARITY strobe, even parity is checked against rx_sync, then -> STOP.
  - Adds output port parity_err (1 bit, reset 0). It pulses one cycle concurrently with rx_valid or frame_err on mismatch.
- Undefined: no PARITY state, no parity_err port, frame is 1+DATA_WIDTH+1 bits.

Test Plan:
- Datapath at 100 MHz/115200/16 (54 clocks/sample, 864/bit); send 0xA5 LSB first with stop = 1 -> exactly one rx_valid pulse about 9.5 bit times after the start edge; data_out = 0xA5; frame_err stays 0.
- rx low glitch of 300 clocks (< 432 to mid-start), then high -> FSM returns to IDLE after the start strobe; no rx_valid or frame_err; busy drops.
- Send 0x3C with stop bit held 0 -> one frame_err pulse, no rx_valid; next frame 0x81 with valid stop -> rx_valid, data_out = 0x81.
- Back-to-back 0x00 then 0xFF with no idle gap -> two rx_valid pulses 10 bit periods apart; data_out = 0x00, then 0xFF.
- Assert reset during bit 4 of a frame -> busy = 0, rx_valid = 0 immediately; after release, a clean 0x5A frame -> rx_valid with data_out = 0x5A.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 1 -> rx_valid, parity_err = 0; send 0x07 with parity bit 0 -> rx_valid and parity_err pulse together.
